// File: rtl/layer_out_serializer.sv
// rtl/layer_out_serializer.sv - collects one layer's neuron results and streams them as a serial frame (optional LAYER_SER_OVF_CNT_EN adds ovf_cnt)
module layer_out_serializer #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            x_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] x_in,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overrun
`ifdef LAYER_SER_OVF_CNT_EN
  ,
  output logic [7:0]                        ovf_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_NEURONS-1:0] cflag_q, cflag_d;
  logic [DATA_WIDTH-1:0]  creg_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  sreg_q [NUM_NEURONS];
  logic                   overrun_q;

  logic [NUM_NEURONS-1:0] take;
  logic [NUM_NEURONS-1:0] drop_vec;
  logic                   any_drop;
  logic                   complete;
  logic                   load;

  // A lane is captured only into an empty slot; a pulse on a full slot is a drop.
  assign take     = x_valid & ~cflag_q;
  assign drop_vec = x_valid & cflag_q;
  assign any_drop = |drop_vec;
  assign complete = &(cflag_q | x_valid);

  // Next-state logic: load into the shifter when idle or on the final word of the current frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (complete) begin
          load    = 1'b1;
          state_d = S_SHIFT;
          idx_d   = '0;
        end
      end
      S_SHIFT: begin
        if (idx_q == LAST_IDX) begin
          if (complete) begin
            load    = 1'b1;
            state_d = S_SHIFT;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Collect flags clear on load, otherwise accumulate newly arrived lanes.
  always_comb begin
    cflag_d = cflag_q | take;
    if (load) begin
      cflag_d = '0;
    end
  end

  // Shifter state register; idx stays on the last word while idle so out_data holds it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Collect buffer: flags plus the captured lane words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cflag_q <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        creg_q[i] <= '0;
      end
    end else begin
      cflag_q <= cflag_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (take[i]) begin
          creg_q[i] <= x_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Shift registers load a whole frame; lanes arriving on the load edge bypass the collect buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        sreg_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        sreg_q[i] <= take[i] ? x_in[i*DATA_WIDTH +: DATA_WIDTH] : creg_q[i];
      end
    end
  end

  // One overrun pulse per cycle with any dropped lane, regardless of how many lanes dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= any_drop;
    end
  end

`ifdef LAYER_SER_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // Saturating count of overrun cycles; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt_q <= '0;
    end else if (any_drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign out_data  = sreg_q[idx_q];
  assign out_valid = (state_q == S_SHIFT);
  assign out_last  = (state_q == S_SHIFT) && (idx_q == LAST_IDX);
  assign busy      = (state_q == S_SHIFT);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// tb/tb_layer_out_serializer.sv - randomized and directed bench for layer_out_serializer against a queue-based frame model
module tb_layer_out_serializer;

  localparam int N = 10;
  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   x_valid;
  logic [N*W-1:0] x_in;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic           busy;
  logic           overrun;
`ifdef LAYER_SER_OVF_CNT_EN
  logic [7:0]     ovf_cnt;
`endif

  layer_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_valid   (x_valid),
    .x_in      (x_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
`ifdef LAYER_SER_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: words still to be shown (bit W = last flag), collect slots, held word.
  logic [W:0]   exp_q[$];
  logic [W-1:0] mreg [N];
  logic [N-1:0] mflag;
  logic [W-1:0] held;
  logic         exp_ovr;
  int           ovf_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    mflag   = '0;
    held    = '0;
    exp_ovr = 1'b0;
    ovf_m   = 0;
    for (int i = 0; i < N; i++) mreg[i] = '0;
  endtask

  task automatic check_outputs();
    if (exp_q.size() > 0) begin
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("out_data", {16'b0, out_data}, {16'b0, exp_q[0][W-1:0]});
      chk("out_last", {31'b0, out_last}, {31'b0, exp_q[0][W]});
      chk("busy", {31'b0, busy}, 32'd1);
    end else begin
      chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
      chk("out_data_held", {16'b0, out_data}, {16'b0, held});
      chk("out_last_idle", {31'b0, out_last}, 32'd0);
      chk("busy_idle", {31'b0, busy}, 32'd0);
    end
    chk("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
`ifdef LAYER_SER_OVF_CNT_EN
    chk("ovf_cnt", {24'b0, ovf_cnt}, ovf_m);
`endif
  endtask

  // Apply one cycle of inputs, advance the model by one edge, then check.
  task automatic step(input logic [N-1:0] vv, input logic [N*W-1:0] xi);
    logic can_load;
    logic is_complete;
    x_valid = vv;
    x_in    = xi;
    exp_ovr     = |(vv & mflag);
    is_complete = &(mflag | vv);
    can_load    = (exp_q.size() <= 1);
    if (exp_q.size() > 0) begin
      held = exp_q[0][W-1:0];
      void'(exp_q.pop_front());
    end
    if (exp_ovr && ovf_m < 255) ovf_m++;
    if (is_complete && can_load) begin
      for (int i = 0; i < N; i++) begin
        logic [W-1:0] w;
        w = mflag[i] ? mreg[i] : xi[i*W +: W];
        exp_q.push_back({(i == N-1), w});
      end
      mflag = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vv[i] && !mflag[i]) begin
          mreg[i]  = xi[i*W +: W];
          mflag[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0);
  endtask

  function automatic logic [N*W-1:0] rand_lanes();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [N*W-1:0] ramp_lanes();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(16'h0100 * i);
    return r;
  endfunction

  task automatic async_reset();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_data", {16'b0, out_data}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    model_clear();
    x_valid = '0;
    x_in    = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_outputs();
  endtask

  initial begin
    logic [N*W-1:0] lanes;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    x_valid  = '0;
    x_in     = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    idle(2);

    // All lanes at once with a ramp of values.
    step('1, ramp_lanes());
    idle(12);

    // Lanes arrive one per cycle from lane 9 down to lane 0.
    for (int k = N-1; k >= 0; k--) step(N'(1) << k, rand_lanes());
    idle(12);

    // Frame B completes while frame A is emitting word 3.
    step('1, rand_lanes());
    idle(3);
    step('1, rand_lanes());
    idle(25);

    // Lane 2 pulses twice before the frame completes; the first value wins.
    lanes = rand_lanes();
    lanes[2*W +: W] = 16'h0AAA;
    step(N'(1) << 2, lanes);
    lanes[2*W +: W] = 16'h0BBB;
    step(N'(1) << 2, lanes);
    step(~(N'(1) << 2), rand_lanes());
    idle(12);

    // Reset while word 5 is on the output, then a fresh frame.
    step('1, rand_lanes());
    idle(5);
    async_reset();
    step('1, ramp_lanes());
    idle(12);

    // Randomized sparse, skewed arrivals with occasional drops and back-to-back frames.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] vv;
      for (int i = 0; i < N; i++) vv[i] = ($urandom_range(0, 5) == 0);
      step(vv, rand_lanes());
    end
    idle(12);

    // Repeated drops on one full lane to exercise overrun counting and saturation.
    step(N'(1), rand_lanes());
    for (int k = 0; k < 300; k++) step(N'(1), rand_lanes());
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
